// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter in front of an 8N1 serial transmitter.
// Ports:
//   clock     system clock, all logic on posedge
//   reset     synchronous active-high reset
//   req       per-requester level request, held until grant is seen
//   req_data  byte for requester i at [8*i+7:8*i]
//   grant     one-hot, one-cycle acceptance pulse (first START cycle)
//   busy      high while a frame (START/DATA/STOP) is on the line
//   tx_line   serial output, idles high
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   tx_line
);

    localparam int unsigned PTR_W  = $clog2(NUM_REQ);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state;
    logic [PTR_W-1:0]    rr_ptr;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [2:0]          bit_cnt;
    logic [7:0]          shift_reg;

    logic                found_c;
    logic [PTR_W-1:0]    winner_c;
    logic                arb_edge_c;

    // Round-robin scan starting at rr_ptr; the modulo keeps the wrap explicit
    // for non-power-of-two requester counts.
    always_comb begin
        found_c  = 1'b0;
        winner_c = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned idx;
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!found_c && req[PTR_W'(idx)]) begin
                found_c  = 1'b1;
                winner_c = PTR_W'(idx);
            end
        end
    end

    // Arbitration happens while idle or on the last cycle of the stop bit,
    // which lets a pending request start the next frame with no idle gap.
    assign arb_edge_c = (state == IDLE) || ((state == STOP) && (baud_cnt == BAUD_MAX));

    // Frame sequencer, bit timer and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            tx_line   <= 1'b1;
        end else begin
            grant <= '0;
            if (arb_edge_c) begin
                baud_cnt <= '0;
                if (found_c) begin
                    shift_reg       <= req_data[{winner_c, 3'b000} +: 8];
                    rr_ptr          <= (winner_c == PTR_LAST) ? '0 : winner_c + PTR_W'(1);
                    grant[winner_c] <= 1'b1;
                    state           <= START;
                    busy            <= 1'b1;
                    tx_line         <= 1'b0;
                end else begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    tx_line <= 1'b1;
                end
            end else if (baud_cnt != BAUD_MAX) begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end else begin
                baud_cnt <= '0;
                case (state)
                    START: begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx_line <= shift_reg[0];
                    end
                    DATA: begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == 3'd7) begin
                            state   <= STOP;
                            tx_line <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_line <= shift_reg[1];
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        tx_line <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler (NUM_REQ=4, CLKS_PER_BIT=4).
module tb_uart_tx_scheduler;

    localparam int NR  = 4;
    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [NR-1:0]    req = '0;
    logic [8*NR-1:0]  req_data = '0;
    logic [NR-1:0]    grant;
    logic             busy;
    logic             tx_line;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int g_q[$];
    int gt_q[$];

    uart_tx_scheduler #(.NUM_REQ(NR), .CLKS_PER_BIT(CPB)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .busy     (busy),
        .tx_line  (tx_line)
    );

    always #5 clock = ~clock;

    // Reference model: a frame is a position t in 0..10*CPB-1; bit k = t/CPB
    // is start (0), data bit k-1, or stop (1). Arbitration when idle or at
    // the final cycle of a frame.
    bit        m_active = 1'b0;
    int        m_t = 0;
    int        m_ptr = 0;
    logic [7:0] m_byte = '0;
    logic       exp_tx = 1'b1;
    logic       exp_busy = 1'b0;
    logic [NR-1:0] exp_grant = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_active  = 1'b0;
            m_ptr     = 0;
            m_t       = 0;
            exp_grant = '0;
        end else begin
            exp_grant = '0;
            if (!m_active || m_t == FRAME - 1) begin
                if (req != '0) begin
                    int w;
                    bit found;
                    w = 0;
                    found = 1'b0;
                    for (int k = 0; k < NR; k++) begin
                        if (!found && req[(m_ptr + k) % NR]) begin
                            found = 1'b1;
                            w = (m_ptr + k) % NR;
                        end
                    end
                    m_byte       = req_data[8*w +: 8];
                    m_ptr        = (w + 1) % NR;
                    m_active     = 1'b1;
                    m_t          = 0;
                    exp_grant[w] = 1'b1;
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_t++;
            end
        end
        if (m_active) begin
            int k;
            k = m_t / CPB;
            exp_busy = 1'b1;
            if (k == 0)      exp_tx = 1'b0;
            else if (k <= 8) exp_tx = m_byte[k-1];
            else             exp_tx = 1'b1;
        end else begin
            exp_busy = 1'b0;
            exp_tx   = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one cycle, compare all outputs to the model, log observed grants.
    task automatic step();
        @(negedge clock);
        cyc++;
        chk("tx_line", 32'(tx_line), 32'(exp_tx));
        chk("busy",    32'(busy),    32'(exp_busy));
        chk("grant",   32'(grant),   32'(exp_grant));
        for (int k = 0; k < NR; k++) begin
            if (grant[k]) begin
                g_q.push_back(k);
                gt_q.push_back(cyc);
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_grant(input int idx, input int bound, input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            step();
            if (grant[idx]) got = 1'b1;
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    initial begin
        logic [9:0] pat;
        logic       rec [0:44];
        int         bcnt, gcnt, bad;
        logic [7:0] b3c;

        // Reset state
        step();
        chk("reset_tx", 32'(tx_line), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_grant", 32'(grant), 32'd0);
        reset = 1'b0;

        // 1: single request 0xA5
        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        bcnt = 0; gcnt = 0;
        for (int i = 0; i < 45; i++) begin
            step();
            if (i == 0) req = 4'b0000;
            rec[i] = tx_line;
            if (busy) bcnt++;
            if (grant[0]) gcnt++;
        end
        pat = 10'b11_0100_1010; // bit b of pat = line level in frame bit b
        for (int b = 0; b < 10; b++) chk($sformatf("t1_bit%0d", b), 32'(rec[b*CPB+2]), 32'(pat[b]));
        chk("t1_busy_cycles", 32'(bcnt), 32'(FRAME));
        chk("t1_grant_count", 32'(gcnt), 32'd1);

        // 2: round-robin fairness, back-to-back frames
        do_reset();
        g_q.delete(); gt_q.delete();
        req_data = 32'h44332211;
        req = 4'b1111;
        steps(4 * FRAME + 2);
        req = 4'b0000;
        steps(FRAME + 5);
        chk("t2_grant_total", 32'(g_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t2_order%0d", i), 32'((i < g_q.size()) ? g_q[i] : -1), 32'(i % NR));
        for (int i = 1; i < 5; i++)
            chk($sformatf("t2_gap%0d", i),
                32'((i < gt_q.size()) ? gt_q[i] - gt_q[i-1] : -1), 32'(FRAME));

        // 3: pointer rotation after a grant to requester 2
        do_reset();
        req_data = {$urandom};
        req = 4'b0100;
        wait_grant(2, 5, "t3_grant2");
        req = 4'b0000;
        steps(FRAME + 2);
        g_q.delete(); gt_q.delete();
        req = 4'b1001;
        wait_grant(3, 5, "t3_grant3");
        req = 4'b0001;
        wait_grant(0, FRAME + 5, "t3_grant0");
        req = 4'b0000;
        steps(FRAME + 2);
        chk("t3_first", 32'((g_q.size() > 0) ? g_q[0] : -1), 32'd3);
        chk("t3_second", 32'((g_q.size() > 1) ? g_q[1] : -1), 32'd0);

        // 4: data sampled only at arbitration
        do_reset();
        b3c = 8'h3C;
        req_data[7:0] = b3c;
        req = 4'b0001;
        for (int i = 0; i < 44; i++) begin
            step();
            if (i == 0) req = 4'b0000;
            if (i == 1) req_data[7:0] = 8'hFF;
            rec[i] = tx_line;
        end
        for (int b = 0; b < 8; b++)
            chk($sformatf("t4_data%0d", b), 32'(rec[(b+1)*CPB+2]), 32'(b3c[b]));

        // 5: reset in third data bit, then priority restarts at requester 0
        do_reset();
        req_data = 32'h5A_6B_7C_8D;
        req = 4'b0001;
        wait_grant(0, 5, "t5_grant0");
        req = 4'b0000;
        steps(3 * CPB + 1); // frame position 13: third data bit
        reset = 1'b1;
        step();
        chk("t5_rst_tx", 32'(tx_line), 32'd1);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_grant", 32'(grant), 32'd0);
        reset = 1'b0;
        g_q.delete(); gt_q.delete();
        req = 4'b0011;
        wait_grant(0, 5, "t5_after_grant0");
        req = 4'b0010;
        wait_grant(1, FRAME + 5, "t5_after_grant1");
        req = 4'b0000;
        steps(FRAME + 2);
        chk("t5_first", 32'((g_q.size() > 0) ? g_q[0] : -1), 32'd0);

        // 6: idle line
        do_reset();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx_line !== 1'b1 || busy !== 1'b0 || grant !== '0) bad++;
        end
        chk("t6_idle_bad", 32'(bad), 32'd0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = NR'($urandom);
            if ($urandom_range(0, 1) == 0) req_data = {$urandom};
            step();
        end
        req = '0;
        steps(FRAME + 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one serial transmit line between NUM_REQ byte requesters using round-robin arbitration. For each granted byte it frames and serialises the data as 8N1: a start bit, 8 data bits LSB first, then a stop bit. It sits between the byte producers (command/status/debug sources) and the board TX pin. It replaces ad-hoc sequencing of the bare shift register with a fixed bit period and a clean request/grant handshake.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 2.

Ports:
clock  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
req  input  NUM_REQ  per-requester level request; held high until the matching grant is seen.
req_data  input  8*NUM_REQ  byte for requester i is at bits [8*i+7:8*i].
grant  output  NUM_REQ  one-hot, one-cycle pulse acknowledging acceptance of requester i's byte.
busy  output  1  high while a frame is on the line (START, DATA or STOP).
tx_line  output  1  serial output; idles high.

Behaviour:
- Synchronous, active-high reset; one clock domain. Everything is registered; there are no combinational paths from inputs to outputs.
- Reset values: tx_line=1, grant=0, busy=0, state=IDLE, rr_ptr=0 (requester 0 has highest priority), bit and baud counters = 0.
- States:
  - IDLE: tx_line=1, busy=0.
  - START: tx_line=0.
  - DATA: tx_line = shift_reg[0], 8 bits.
  - STOP: tx_line=1.
- Arbitration edge: any posedge where state==IDLE, or where state==STOP and baud_cnt==CLKS_PER_BIT-1. At that edge, if req!=0:
  - winner = first set req bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ;
  - shift_reg <= winner's req_data slice (data is sampled only at this edge);
  - rr_ptr <= (winner+1) mod NUM_REQ;
  - state <= START, baud_cnt <= 0, busy <= 1, tx_line <= 0;
  - grant[winner] <= 1 for exactly the next cycle.
- At an arbitration edge with req==0: state <= IDLE and tx_line stays or returns to 1.
- Back-to-back frames: a request pending at the STOP arbitration edge starts the next START with zero idle cycles. The stop bit is still a full CLKS_PER_BIT cycles.
- Bit timing: every START, DATA and STOP bit holds for exactly CLKS_PER_BIT cycles. baud_cnt counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. A frame is exactly 10*CLKS_PER_BIT cycles from the tx_line falling edge to the end of the stop bit.
- Transitions on the baud_cnt wrap edge:
  - START -> DATA with bit_cnt=0.
  - DATA: shift_reg >>= 1 and bit_cnt++ after each bit. After bit_cnt==7 completes -> STOP.
  - STOP: leaves via the arbitration rule above.
- Handshake:
  - The requester holds req and its data stable until it samples grant[i]=1, then may drop req on the next edge.
  - Because grant is issued in the first START cycle, and no arbitration happens for 10*CLKS_PER_BIT cycles, holding req one cycle past grant cannot cause a double accept.
  - If req[i] is still high at the next arbitration edge, that is a new request carrying whatever data is then present.
- Changes to req or req_data between arbitration edges have no effect. Dropping req before grant withdraws the request without side effects.
- grant is never multi-hot. grant stays 0 while state is START (after its first cycle), DATA or STOP, except at arbitration edges.
- Reset mid-frame: on the reset edge tx_line=1, busy=0, state=IDLE, rr_ptr=0. The partial frame is abandoned and no grant is issued.
- Width rules: baud_cnt is $clog2(CLKS_PER_BIT) bits, bit_cnt is 3 bits, rr_ptr is $clog2(NUM_REQ) bits. The wrap of rr_ptr is explicit when NUM_REQ is not a power of two.

Test Plan:
1. Single request, CLKS_PER_BIT=4: req=4'b0001 with byte 0xA5 -> grant[0] pulses once. tx_line per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1, then returns to IDLE (busy 1 for exactly 40 cycles).
2. Round-robin fairness: req=4'b1111 held with distinct bytes 0x11/0x22/0x33/0x44 -> grants in order 0,1,2,3,0. Frames are back-to-back with no idle gap, and each grant is spaced 40 cycles apart.
3. Pointer rotation: after a grant to requester 2, assert req0 and req3 together -> requester 3 is served first, then requester 0.
4. Data stability: change req_data[7:0] from 0x3C to 0xFF one cycle after grant[0] -> the line still carries 0x3C.
5. Reset mid-frame: assert reset in the 3rd DATA bit -> the next cycle has tx_line=1, busy=0, grant=0. A subsequent req1 is served with priority order starting at requester 0.
6. Idle: req=0 for 100 cycles after reset -> tx_line=1, busy=0, grant=0 throughout.
